// File: rtl/param_updown_counter.sv
// Modulo up/down counter with sync clear, clamped parallel load, wrap/saturate mode and a registered tc pulse.
// Optional feature macro UDC_WRAP_CNT_EN adds wrap_cnt, a saturating count of tc events.
module param_updown_counter #(
    parameter int WIDTH      = 4,
    parameter int MAX        = (2**WIDTH)-1,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  en,
    input  logic                  up,
    input  logic                  sat,
    output logic [WIDTH-1:0]      q,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  tc
`ifdef UDC_WRAP_CNT_EN
    ,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;

    // Boundary steps (up at MAX, down at 0) raise tc whether they wrap or are blocked.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (up) begin
                if (q_q == MAX_V) begin
                    tc_d = 1'b1;
                    q_d  = sat ? q_q : '0;
                end else begin
                    q_d = q_q + WIDTH'(1'b1);
                end
            end else begin
                if (q_q == '0) begin
                    tc_d = 1'b1;
                    q_d  = sat ? q_q : MAX_V;
                end else begin
                    q_d = q_q - WIDTH'(1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q      = q_q;
    assign tc     = tc_q;
    assign at_max = (q_q == MAX_V);
    assign at_min = (q_q == '0);

`ifdef UDC_WRAP_CNT_EN
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    // Saturates at all-ones rather than rolling over; load leaves it untouched.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clr) begin
            wrap_cnt_d = '0;
        end else if (tc_d && (wrap_cnt_q != {WRAP_CNT_W{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised modulo up/down counter. It generalises the basic free-running up counter with:
  - programmable modulus
  - direction control
  - count enable
  - synchronous clear and parallel load
  - wrap or saturate mode
  - registered terminal-count event
- Used as a general timebase, divider and event counter in datapath and control blocks.
- Output q is taken directly from the state register; there is no combinational path from inputs to q.

Parameters:
- WIDTH, 4: counter width in bits. Legal range 1..32.
- MAX, (2**WIDTH)-1: highest count value. Count range is 0..MAX. Must satisfy 1 <= MAX <= 2**WIDTH-1.
- WRAP_CNT_W, 8: width of the wrap-event counter. Used only when UDC_WRAP_CNT_EN is defined.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value to load
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- sat  input  1  boundary mode: 0 = wrap, 1 = saturate
- q  output  WIDTH  current count (registered)
- at_max  output  1  combinational, q == MAX
- at_min  output  1  combinational, q == 0
- tc  output  1  registered terminal-count event pulse
- wrap_cnt  output  WRAP_CNT_W  present only with UDC_WRAP_CNT_EN

Behaviour:
- Reset: reset_n low asynchronously forces q=0, tc=0 and wrap_cnt=0. Release is synchronous to the next clk edge. A reset asserted mid-count aborts the count immediately; no pending tc survives reset.
- Per-edge priority: clr > load > en > hold.
- clr=1: q<=0, tc<=0. The current direction and mode are ignored.
- load=1 (clr=0): q<=load_val. If load_val > MAX, q<=MAX (clamped). tc<=0. A load never generates tc.
- en=1, up=1, q<MAX: q<=q+1, tc<=0.
- en=1, up=1, q==MAX:
  - sat=0: q<=0, tc<=1 (wrap).
  - sat=1: q holds MAX, tc<=1 (blocked step).
- en=1, up=0, q>0: q<=q-1, tc<=0.
- en=1, up=0, q==0:
  - sat=0: q<=MAX, tc<=1.
  - sat=1: q holds 0, tc<=1.
- en=0 (no clr/load): q holds, tc<=0.
- tc timing: tc is a single-cycle pulse per event, visible in the cycle after the boundary edge. Repeated blocked steps in saturate mode produce tc high on every such cycle.
- up and sat may change on any cycle. The new value takes effect on the same edge; there is no pipelining.
- Arithmetic: all next-state arithmetic is modulo the boundary rules above. Intermediate WIDTH+1 overflow is never exposed. When MAX = 2**WIDTH-1, wrap coincides with natural binary rollover.
- Latency: q reflects a control input one clock after it is sampled. at_max and at_min follow q with zero additional latency.

Optional Feature:
- Macro: UDC_WRAP_CNT_EN.
- Defined:
  - Adds output wrap_cnt[WRAP_CNT_W-1:0]. It increments on every edge where tc is set to 1 and saturates at all-ones; it does not roll over.
  - Cleared by reset_n and by clr. Unaffected by load.
- Undefined: wrap_cnt port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=4, MAX=9 unless noted):
- Reset/up wrap: reset_n low, then en=1, up=1, sat=0 for 12 cycles -> q = 1..9, 0, 1, 2. tc high exactly one cycle after q goes 9->0. at_max high while q=9.
- Down wrap and saturate: load_val=2, load=1, then en=1, up=0, sat=0 -> q = 2, 1, 0, 9 with tc after 0->9. Repeat with sat=1 -> q = 2, 1, 0, 0, 0 with tc high on each blocked cycle.
- Priority/clamp: clr=1, load=1, load_val=5, en=1 on the same edge -> q=0. Next edge: load=1, load_val=15 -> q=9 (clamped), tc=0.
- Enable/direction changes: en toggled 1,0,1 and up flipped mid-stream from q=4 -> q = 5, 5, 4. No tc.
- Async reset mid-operation: count to q=7, assert reset_n between edges -> q=0 and tc=0 immediately. First enabled edge after release -> q=1.
- UDC_WRAP_CNT_EN, WRAP_CNT_W=2: force 5 wraps -> wrap_cnt = 1, 2, 3, 3, 3. clr -> wrap_cnt=0. Build without the macro compiles with the port absent.
